compressor_env: RTL and testbench



---
 rtl/compressor_env.sv | 172 +++++++++++++++++
 tb/tb_compressor_env.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/compressor_env.sv
// Envelope-following dynamic range compressor: peak envelope with attack/release,
// smoothed gain from a serial restoring divider, applied to one sample at a time.
module compressor_env #(
    parameter int DATA_W    = 16,
    parameter int CTRL_W    = 8,
    parameter int ATK_SHIFT = 2,
    parameter int REL_SHIFT = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] audio_in,
    input  logic [CTRL_W-1:0]        threshold,
    input  logic [CTRL_W-1:0]        ratio,
    input  logic                     bypass,
    output logic signed [DATA_W-1:0] audio_out,
    output logic                     out_valid,
    output logic [DATA_W-2:0]        env_o,
    output logic                     gr_active
);

    localparam int MW = DATA_W - 1;
    localparam int CW = $clog2(DATA_W);
    localparam logic [DATA_W-1:0]        UNITY = {1'b1, {MW{1'b0}}};
    localparam logic signed [DATA_W-1:0] MIN_X = {1'b1, {MW{1'b0}}};

    typedef enum logic [2:0] {IDLE, DETECT, DIVIDE, APPLY, OUT} state_t;

    state_t state, state_next;

    logic signed [DATA_W-1:0] x_q;
    logic [CTRL_W-1:0]        thr_code_q;
    logic [CTRL_W-1:0]        ratio_q;
    logic                     bypass_q;
    logic [MW-1:0]            env_q;
    logic [DATA_W-1:0]        gain_q;
    logic [MW-1:0]            rem_q;
    logic                     tgt_lsb_q;
    logic [CW-1:0]            cnt_q;

    logic signed [DATA_W-1:0]   neg_x;
    logic [MW-1:0]              mag, thr, step_up, step_dn, env_next, excess, target;
    logic [MW+CTRL_W-1:0]       slope_prod;
    logic                       compress;
    logic [MW:0]                trial;
    logic                       qbit;
    logic [MW-1:0]              rem_next;
    logic signed [2*DATA_W:0]   prod;
    logic signed [DATA_W-1:0]   y;

    // Detection, envelope update, divider step and gain application datapath
    always_comb begin
        neg_x = -x_q;
        if (x_q == MIN_X)
            mag = '1;
        else if (x_q[DATA_W-1])
            mag = MW'(neg_x);
        else
            mag = MW'(x_q);

        thr = MW'(thr_code_q) << (MW - CTRL_W);

        step_up = (mag - env_q) >> ATK_SHIFT;
        if (step_up == '0)
            step_up = MW'(1);
        step_dn = (env_q - mag) >> REL_SHIFT;
        if (step_dn == '0)
            step_dn = MW'(1);

        env_next = env_q;
        if (mag > env_q)
            env_next = env_q + step_up;
        else if (mag < env_q)
            env_next = env_q - step_dn;

        excess     = env_next - thr;
        slope_prod = (MW+CTRL_W)'(excess) * (MW+CTRL_W)'(ratio_q);
        target     = thr + MW'(slope_prod >> CTRL_W);
        compress   = !bypass_q && (env_next > thr);

        // Dividend is target << (DATA_W-1): its lsb enters on the first step, zeros after
        trial    = {rem_q, (cnt_q == '0) ? tgt_lsb_q : 1'b0};
        qbit     = (trial >= {1'b0, env_q});
        rem_next = qbit ? MW'(trial - {1'b0, env_q}) : MW'(trial);

        prod = x_q * $signed({1'b0, gain_q});
        y    = DATA_W'(prod >>> (DATA_W - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = DETECT;
            end
            DETECT: state_next = compress ? DIVIDE : APPLY;
            DIVIDE: begin
                if (cnt_q == CW'(DATA_W - 1))
                    state_next = APPLY;
            end
            APPLY: state_next = OUT;
            OUT: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                state_next = in_valid ? DETECT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output is registered at the end of APPLY so it is valid during the OUT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            thr_code_q <= '0;
            ratio_q    <= '0;
            bypass_q   <= 1'b0;
            env_q      <= '0;
            gain_q     <= '0;
            rem_q      <= '0;
            tgt_lsb_q  <= 1'b0;
            cnt_q      <= '0;
            audio_out  <= '0;
            gr_active  <= 1'b0;
        end else begin
            if (in_ready && in_valid) begin
                x_q        <= audio_in;
                thr_code_q <= threshold;
                ratio_q    <= ratio;
                bypass_q   <= bypass;
            end
            case (state)
                DETECT: begin
                    env_q <= env_next;
                    if (compress) begin
                        gain_q    <= '0;
                        rem_q     <= target >> 1;
                        tgt_lsb_q <= target[0];
                        cnt_q     <= '0;
                    end else begin
                        gain_q <= UNITY;
                    end
                end
                DIVIDE: begin
                    gain_q <= {gain_q[DATA_W-2:0], qbit};
                    rem_q  <= rem_next;
                    cnt_q  <= cnt_q + 1'b1;
                end
                APPLY: begin
                    audio_out <= y;
                    gr_active <= (gain_q < UNITY);
                end
                default: ;
            endcase
        end
    end

    assign env_o = env_q;

endmodule

// File: tb/tb_compressor_env.sv
// Self-checking bench for compressor_env: vector table fed back-to-back through a
// scoreboard, plus hand sequences for limiter, mid-divide reset and busy inputs.
module tb_compressor_env;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 8;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] audio_in;
    logic [CTRL_W-1:0]        threshold;
    logic [CTRL_W-1:0]        ratio;
    logic                     bypass;
    logic signed [DATA_W-1:0] audio_out;
    logic                     out_valid;
    logic [DATA_W-2:0]        env_o;
    logic                     gr_active;

    compressor_env #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .ATK_SHIFT(0), .REL_SHIFT(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .audio_in(audio_in), .threshold(threshold), .ratio(ratio), .bypass(bypass),
        .audio_out(audio_out), .out_valid(out_valid), .env_o(env_o), .gr_active(gr_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x; int thr; int ratio; int byp;
        int exp_out; int exp_env; int exp_gr; int exp_lat;
    } vec_t;

    typedef struct {
        int out; int env; int gr; int lat; int acc;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    int   cycle_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle_cnt);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit expect_out);
        int waited = 0;
        exp_t e;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 0, 1);
            return;
        end
        audio_in  = DATA_W'(v.x);
        threshold = CTRL_W'(v.thr);
        ratio     = CTRL_W'(v.ratio);
        bypass    = v.byp[0];
        in_valid  = 1'b1;
        if (expect_out) begin
            e.out = v.exp_out;
            e.env = v.exp_env;
            e.gr  = v.exp_gr;
            e.lat = v.exp_lat;
            e.acc = cycle_cnt;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard_drain", sb.size(), 0);
        sb.delete();
    endtask

    // Every output pulse is matched against the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("audio_out", int'(audio_out), e.out);
                checkOutput("env_o", int'(env_o), e.env);
                checkOutput("gr_active", int'(gr_active), e.gr);
                checkOutput("latency", cycle_cnt - e.acc, e.lat);
            end
        end
    end

    initial begin
        int pulses;
        vec_t v;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        audio_in  = '0;
        threshold = '0;
        ratio     = '0;
        bypass    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_audio_out", int'(audio_out), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_in_ready", int'(in_ready), 1);
        checkOutput("rst_env_o", int'(env_o), 0);
        checkOutput("rst_gr_active", int'(gr_active), 0);

        //          x       thr  ratio byp  out     env    gr lat
        vecs[0] = '{4000,   64,  128,  0,   4000,   4000,  0, 3};
        vecs[1] = '{16384,  64,  128,  0,   12288,  16384, 1, 19};
        vecs[2] = '{-16384, 64,  128,  0,   -12288, 16384, 1, 19};
        vecs[3] = '{20000,  64,  128,  1,   20000,  20000, 0, 3};
        vecs[4] = '{0,      64,  128,  0,   0,      19688, 1, 19};
        vecs[5] = '{-1,     0,   255,  0,   -1,     19381, 1, 19};
        vecs[6] = '{19381,  255, 0,    0,   19381,  19381, 0, 3};

        $display("[TB] vector table");
        for (int i = 0; i < 7; i++)
            applyStimulus(vecs[i], 1'b1);
        waitDrain();

        $display("[TB] full-scale limiter");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{-32768, 255, 0, 0, -32640, 32767, 1, 19};
        applyStimulus(v, 1'b1);
        waitDrain();

        $display("[TB] reset during divide");
        v = '{16384, 64, 128, 0, 0, 0, 0, 0};
        applyStimulus(v, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_env_o", int'(env_o), 0);
        checkOutput("abort_audio_out", int'(audio_out), 0);
        checkOutput("abort_in_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checkOutput("abort_no_out_valid", pulses, 0);
        checkOutput("abort_env_after", int'(env_o), 0);
        checkOutput("abort_ready_after", int'(in_ready), 1);

        $display("[TB] inputs while busy");
        v = '{16384, 64, 128, 0, 12288, 16384, 1, 19};
        applyStimulus(v, 1'b1);
        audio_in = -16'sd999;
        bypass   = 1'b1;
        in_valid = 1'b1;
        repeat (10) @(negedge clk);
        in_valid = 1'b0;
        bypass   = 1'b0;
        waitDrain();
        repeat (5) @(negedge clk);
        checkOutput("busy_env", int'(env_o), 16384);
        checkOutput("busy_in_ready", int'(in_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
